// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial two's-complement subtractor (a - b), LSB first,
//               built from one full-subtractor cell and a borrow flop.
//               Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;

    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_next;

    // Full-subtractor cell operating on the current LSBs
    assign w_d    = r_a[0] ^ r_b[0] ^ r_borrow;
    assign w_bout = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
    assign w_next = {w_d, r_res};

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are shifted out during RUN, so keep a copy
    logic r_a_msb;
    logic r_b_msb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
            end
            if (r_state == S_RUN && r_cnt == C_LAST) begin
                overflow <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_borrow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_res    <= '0;
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res    <= w_next[WIDTH-1:1];
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        diff       <= w_next;
                        borrow_out <= w_bout;
                        done       <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed self-checking bench for serial_subtractor, WIDTH = 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             overflow;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow   (overflow)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation: accept at edge 0, optional extra start pulse at edge
    // extra_edge, run until busy drops (bounded).
    task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input int extra_edge,
                          output int done_edge, output int busy_cyc, output int n_done,
                          output logic [7:0] rd, output logic rbo, output logic rov);
        done_edge = -1; busy_cyc = 0; n_done = 0; rd = '0; rbo = 1'b0; rov = 1'b0;
        a = oa; b = ob; start = 1'b1;
        step();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        if (busy) busy_cyc++;
        for (int e = 1; e <= 30; e++) begin
            if (e == extra_edge) begin
                start = 1'b1; a = 8'hAA; b = 8'h55;
            end
            step();
            start = 1'b0;
            if (done) begin
                n_done++;
                done_edge = e;
                rd  = diff;
                rbo = borrow_out;
`ifdef SERIAL_SUB_OVF_EN
                rov = overflow;
`endif
            end
            if (busy) busy_cyc++;
            else break;
        end
    endtask

    int          de, bc, nd;
    logic [7:0]  rd;
    logic        rbo, rov;
    int          d1, d2, hold_bad, seen;

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        #12;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_diff", {24'b0, diff}, 32'd0);
        chk("reset_borrow", {31'b0, borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("reset_ovf", {31'b0, overflow}, 32'd0);
`endif
        @(negedge clk); reset = 1'b0;
        step();

        // Basic: 0x5A - 0x23 = 0x37
        run_op(8'h5A, 8'h23, 0, de, bc, nd, rd, rbo, rov);
        chk("basic_latency", de, 8);
        chk("basic_busy_cycles", bc, 9);
        chk("basic_done_count", nd, 1);
        chk("basic_diff", {24'b0, rd}, 32'h37);
        chk("basic_borrow", {31'b0, rbo}, 32'd0);
        chk("basic_diff_hold", {24'b0, diff}, 32'h37);

        // Underflow and equal operands
        run_op(8'h00, 8'h01, 0, de, bc, nd, rd, rbo, rov);
        chk("under_diff", {24'b0, rd}, 32'hFF);
        chk("under_borrow", {31'b0, rbo}, 32'd1);
        run_op(8'hFF, 8'hFF, 0, de, bc, nd, rd, rbo, rov);
        chk("equal_diff", {24'b0, rd}, 32'h00);
        chk("equal_borrow", {31'b0, rbo}, 32'd0);

        // Start while busy is dropped
        run_op(8'h10, 8'h01, 3, de, bc, nd, rd, rbo, rov);
        chk("busy_start_done_count", nd, 1);
        chk("busy_start_diff", {24'b0, rd}, 32'h0F);
        chk("busy_start_latency", de, 8);
        step(); step(); step();
        chk("busy_start_no_requeue", {31'b0, busy}, 32'd0);

        // Reset mid-operation
        a = 8'h33; b = 8'h11; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_diff", {24'b0, diff}, 32'd0);
        step(); step();
        chk("midrst_no_done", {31'b0, done}, 32'd0);
        @(negedge clk); reset = 1'b0;
        step();
        run_op(8'h09, 8'h04, 0, de, bc, nd, rd, rbo, rov);
        chk("after_rst_latency", de, 8);
        chk("after_rst_diff", {24'b0, rd}, 32'h05);

`ifdef SERIAL_SUB_OVF_EN
        run_op(8'h80, 8'h01, 0, de, bc, nd, rd, rbo, rov);
        chk("ovf1_diff", {24'b0, rd}, 32'h7F);
        chk("ovf1_borrow", {31'b0, rbo}, 32'd0);
        chk("ovf1_ovf", {31'b0, rov}, 32'd1);
        run_op(8'h7F, 8'hFF, 0, de, bc, nd, rd, rbo, rov);
        chk("ovf2_diff", {24'b0, rd}, 32'h80);
        chk("ovf2_borrow", {31'b0, rbo}, 32'd1);
        chk("ovf2_ovf", {31'b0, rov}, 32'd1);
        run_op(8'h05, 8'h03, 0, de, bc, nd, rd, rbo, rov);
        chk("ovf3_diff", {24'b0, rd}, 32'h02);
        chk("ovf3_ovf", {31'b0, rov}, 32'd0);
`endif

        // Back-to-back with start held high
        d1 = -1; d2 = -1; hold_bad = 0; seen = 0;
        a = 8'h20; b = 8'h10; start = 1'b1;
        step();
        a = 8'h03; b = 8'h07;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (done) begin
                seen++;
                if (seen == 1) begin
                    d1 = e;
                    chk("b2b_diff1", {24'b0, diff}, 32'h10);
                    chk("b2b_borrow1", {31'b0, borrow_out}, 32'd0);
                end else begin
                    d2 = e;
                    chk("b2b_diff2", {24'b0, diff}, 32'hFC);
                    chk("b2b_borrow2", {31'b0, borrow_out}, 32'd1);
                    start = 1'b0;
                    break;
                end
            end else if (seen == 1 && diff !== 8'h10) begin
                hold_bad++;
            end
        end
        start = 1'b0;
        chk("b2b_first_latency", d1, 8);
        chk("b2b_spacing", d2 - d1, 10);
        chk("b2b_diff_hold", hold_bad, 0);
        step(); step();
        chk("b2b_idle", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
